spi_slave_if_gen2: RTL

Parametrised second-generation SPI slave front end. It deserialises MOSI frames of `2 + PAYLOAD_W` bits into a command/payload word for the RAM-side consumer. For read-data commands, it serialises the returned `tx_data` onto MISO. Compared with the first generation, it adds:
- a configurable payload width,
- an explicit wait-for-`tx_valid` handshake,
- read-sequence checking,
- clean frame-abort reporting.

---
 rtl/spi_slave_pkg.sv | 17 +
 rtl/spi_tx_shifter.sv | 50 +++++
 rtl/spi_slave_if_gen2.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_pkg.sv
// Shared types and command codes for the second-generation SPI slave front end.
package spi_slave_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RX,
    RD_WAIT,
    RD_SHIFT,
    DONE
  } spi_state_t;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_tx_shifter.sv
// MISO serialiser: MSB is driven on the load edge, the remaining bits one per shift edge,
// then MISO returns to 0 on the shift edge after the last bit.
module spi_tx_shifter #(
  parameter int PAYLOAD_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 shift,
  input  logic                 clr,
  input  logic [PAYLOAD_W-1:0] din,
  output logic                 MISO,
  output logic                 last
);

  localparam int SC_W = $clog2(PAYLOAD_W);

  logic [PAYLOAD_W-2:0] r_sreg;
  logic [SC_W-1:0]      r_cnt;
  logic                 r_miso;

  // r_cnt counts the bits still waiting in r_sreg; zero means the last bit is on MISO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sreg <= '0;
      r_cnt  <= '0;
      r_miso <= 1'b0;
    end else if (clr) begin
      r_sreg <= '0;
      r_cnt  <= '0;
      r_miso <= 1'b0;
    end else if (load) begin
      r_miso <= din[PAYLOAD_W-1];
      r_sreg <= din[PAYLOAD_W-2:0];
      r_cnt  <= SC_W'(PAYLOAD_W-1);
    end else if (shift) begin
      if (r_cnt != '0) begin
        r_miso <= r_sreg[PAYLOAD_W-2];
        r_sreg <= r_sreg << 1;
        r_cnt  <= r_cnt - SC_W'(1);
      end else begin
        r_miso <= 1'b0;
      end
    end
  end

  assign MISO = r_miso;
  assign last = (r_cnt == '0);

endmodule

// File: rtl/spi_slave_if_gen2.sv
// SPI slave front end: deserialises {cmd, payload} frames, serves read-data commands
// from tx_data over MISO, and flags aborted frames and out-of-sequence reads.
//
// state    | meaning
// IDLE     | waiting for SS_n to fall
// RX       | shifting in the 2+PAYLOAD_W frame bits
// RD_WAIT  | read-data accepted, waiting for tx_valid
// RD_SHIFT | serialising tx_data onto MISO
// DONE     | frame finished, waiting for SS_n to rise
module spi_slave_if_gen2
  import spi_slave_pkg::*;
#(
  parameter int PAYLOAD_W = 8,
  parameter int CNT_W     = $clog2(PAYLOAD_W+2)+1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 SS_n,
  input  logic                 MOSI,
  output logic                 MISO,
  output logic [PAYLOAD_W+1:0] rx_data,
  output logic                 rx_valid,
  input  logic [PAYLOAD_W-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 frame_err,
  output logic                 seq_err,
  output logic                 busy
);

  spi_state_t           r_state;
  spi_state_t           w_state_nxt;
  logic [CNT_W-1:0]     r_bit_cnt;
  logic [PAYLOAD_W:0]   r_shift;
  logic [PAYLOAD_W+1:0] r_rx_data;
  logic                 r_rx_valid;
  logic                 r_frame_err;
  logic                 r_seq_err;
  logic                 r_busy;
  logic                 r_rd_pend;

  logic [PAYLOAD_W+1:0] w_frame;
  logic [1:0]           w_cmd;
  logic                 w_last_bit;
  logic                 w_cnt_clr;
  logic                 w_rx_shift;
  logic                 w_rx_load;
  logic                 w_seq_err;
  logic                 w_frame_err;
  logic                 w_pend_set;
  logic                 w_pend_clr;
  logic                 w_tx_load;
  logic                 w_tx_shift;
  logic                 w_tx_clr;
  logic                 w_tx_last;

  assign w_frame    = {r_shift, MOSI};
  assign w_cmd      = w_frame[PAYLOAD_W+1:PAYLOAD_W];
  assign w_last_bit = (r_bit_cnt == CNT_W'(PAYLOAD_W+1));

  // SS_n high is checked first in every active state, so it wins over completion
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_clr   = 1'b0;
    w_rx_shift  = 1'b0;
    w_rx_load   = 1'b0;
    w_seq_err   = 1'b0;
    w_frame_err = 1'b0;
    w_pend_set  = 1'b0;
    w_pend_clr  = 1'b0;
    w_tx_load   = 1'b0;
    w_tx_shift  = 1'b0;
    w_tx_clr    = 1'b0;
    case (r_state)
      IDLE: begin
        if (!SS_n) begin
          w_state_nxt = RX;
          w_cnt_clr   = 1'b1;
        end
      end
      RX: begin
        if (SS_n) begin
          w_state_nxt = IDLE;
          w_frame_err = 1'b1;
        end else begin
          w_rx_shift = 1'b1;
          if (w_last_bit) begin
            if (w_cmd == CMD_RD_DATA) begin
              if (r_rd_pend) begin
                w_rx_load   = 1'b1;
                w_pend_clr  = 1'b1;
                w_state_nxt = RD_WAIT;
              end else begin
                w_seq_err   = 1'b1;
                w_state_nxt = DONE;
              end
            end else begin
              w_rx_load   = 1'b1;
              w_pend_set  = (w_cmd == CMD_RD_ADDR);
              w_state_nxt = DONE;
            end
          end
        end
      end
      RD_WAIT: begin
        if (SS_n) begin
          w_state_nxt = IDLE;
          w_frame_err = 1'b1;
          w_tx_clr    = 1'b1;
        end else if (tx_valid) begin
          w_tx_load   = 1'b1;
          w_state_nxt = RD_SHIFT;
        end
      end
      RD_SHIFT: begin
        if (SS_n) begin
          w_state_nxt = IDLE;
          w_frame_err = 1'b1;
          w_tx_clr    = 1'b1;
        end else begin
          w_tx_shift = 1'b1;
          if (w_tx_last) w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (SS_n) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_seq_err   <= 1'b0;
      r_busy      <= 1'b0;
      r_rd_pend   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_rx_valid  <= w_rx_load;
      r_frame_err <= w_frame_err;
      r_seq_err   <= w_seq_err;
      r_busy      <= (w_state_nxt != IDLE);
      if (w_cnt_clr) begin
        r_bit_cnt <= '0;
      end else if (w_rx_shift) begin
        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
        r_shift   <= w_frame[PAYLOAD_W:0];
      end
      if (w_rx_load) r_rx_data <= w_frame;
      if (w_pend_set) begin
        r_rd_pend <= 1'b1;
      end else if (w_pend_clr) begin
        r_rd_pend <= 1'b0;
      end
    end
  end

  spi_tx_shifter #(
    .PAYLOAD_W (PAYLOAD_W)
  ) u_tx_shifter (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (w_tx_load),
    .shift (w_tx_shift),
    .clr   (w_tx_clr),
    .din   (tx_data),
    .MISO  (MISO),
    .last  (w_tx_last)
  );

  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;
  assign seq_err   = r_seq_err;
  assign busy      = r_busy;

endmodule
